// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pwm_decoder
// Description : Measures period, high time and 8-bit duty of an async PWM input
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_decoder #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [7:0]       duty_cycle,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             stuck,
    output logic             overrun_err
);

    localparam logic [0:0]       c_ST_IDLE    = 1'b0;
    localparam logic [0:0]       c_ST_MEASURE = 1'b1;
    localparam logic [0:0]       c_DIV_IDLE   = 1'b0;
    localparam logic [0:0]       c_DIV_RUN    = 1'b1;
    localparam logic [3:0]       c_DIV_LAST   = 4'd8;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             r_s1, r_s2, r_s3;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_tmo_pend;

    logic [0:0]       r_div_state;
    logic [3:0]       r_div_cnt;
    logic [CNT_W:0]   r_div_rem;
    logic [CNT_W-1:0] r_div_den;
    logic [7:0]       r_div_quo;
    logic [CNT_W-1:0] r_div_p;
    logic [CNT_W-1:0] r_div_h;

    logic             w_edge;
    logic             w_measure_edge;
    logic             w_launch;
    logic             w_div_ge;
    logic [CNT_W:0]   w_div_sub;
    logic [8:0]       w_div_q9;
    logic             w_div_done;
    logic [7:0]       w_duty_div;
    logic             w_tmo_hit;
    logic             w_tmo_fire;
    logic             w_tmo_defer;

    assign w_edge         = r_s2 & ~r_s3;
    assign w_measure_edge = w_edge & (r_state == c_ST_MEASURE);
    assign w_launch       = w_measure_edge & (r_div_state == c_DIV_IDLE);
    assign overrun_err    = ~reset & w_measure_edge & (r_div_state == c_DIV_RUN);

    // Remainder stays below 2*P, so one compare/subtract yields each quotient bit
    assign w_div_ge   = (r_div_rem >= {1'b0, r_div_den});
    assign w_div_sub  = w_div_ge ? (r_div_rem - {1'b0, r_div_den}) : r_div_rem;
    assign w_div_q9   = {r_div_quo, w_div_ge};
    assign w_div_done = (r_div_state == c_DIV_RUN) && (r_div_cnt == c_DIV_LAST);
    assign w_duty_div = w_div_q9[8] ? 8'hFF : w_div_q9[7:0];

    // A timeout colliding with a divider completion is postponed by one cycle
    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);
    assign w_tmo_fire  = ~w_edge & (r_tmo_pend | (w_tmo_hit & ~w_div_done));
    assign w_tmo_defer = ~w_edge & ~r_tmo_pend & w_tmo_hit & w_div_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_tmo_pend   <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (w_edge) begin
                r_state <= c_ST_MEASURE;
            end else if (w_tmo_fire) begin
                r_state <= c_ST_IDLE;
            end

            if (w_edge) begin
                r_period_cnt <= CNT_W'(1);
                r_high_cnt   <= CNT_W'(1);
            end else begin
                if (r_period_cnt != c_CNT_MAX) begin
                    r_period_cnt <= r_period_cnt + CNT_W'(1);
                end
                if (r_s2 && (r_high_cnt != c_CNT_MAX)) begin
                    r_high_cnt <= r_high_cnt + CNT_W'(1);
                end
            end

            if (w_edge || w_tmo_fire) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
            r_tmo_pend <= w_tmo_defer;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_state <= c_DIV_IDLE;
            r_div_cnt   <= '0;
            r_div_rem   <= '0;
            r_div_den   <= '0;
            r_div_quo   <= '0;
            r_div_p     <= '0;
            r_div_h     <= '0;
        end else if (w_launch) begin
            r_div_state <= c_DIV_RUN;
            r_div_cnt   <= '0;
            r_div_rem   <= {1'b0, r_high_cnt};
            r_div_den   <= r_period_cnt;
            r_div_quo   <= '0;
            r_div_p     <= r_period_cnt;
            r_div_h     <= r_high_cnt;
        end else if (r_div_state == c_DIV_RUN) begin
            r_div_rem <= {w_div_sub[CNT_W-1:0], 1'b0};
            r_div_quo <= {r_div_quo[6:0], w_div_ge};
            if (w_div_done) begin
                r_div_state <= c_DIV_IDLE;
                r_div_cnt   <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_cycle <= '0;
            duty_valid <= 1'b0;
            period_out <= '0;
            high_out   <= '0;
            stuck      <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (w_div_done) begin
                duty_cycle <= w_duty_div;
                period_out <= r_div_p;
                high_out   <= r_div_h;
                duty_valid <= 1'b1;
            end else if (w_tmo_fire) begin
                duty_cycle <= r_s2 ? 8'hFF : 8'h00;
                duty_valid <= 1'b1;
            end

            if (w_edge) begin
                stuck <= 1'b0;
            end else if (w_tmo_fire) begin
                stuck <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_decoder
// Description : Directed self-checking bench for pwm_decoder
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [7:0]  duty_cycle;
    logic        duty_valid;
    logic [15:0] period_out;
    logic [15:0] high_out;
    logic        stuck;
    logic        overrun_err;

    int n_checks = 0;
    int n_errors = 0;
    int gen_per = 256;
    int gen_hi = 0;
    int gcnt = 0;
    bit gen_en = 1'b0;

    pwm_decoder #(.CNT_W(16), .TIMEOUT_CYCLES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .duty_valid (duty_valid),
        .period_out (period_out),
        .high_out   (high_out),
        .stuck      (stuck),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge
    task automatic step();
        @(negedge clk);
        if (gen_en) begin
            pwm_in = (gcnt < gen_hi);
            gcnt = (gcnt + 1 >= gen_per) ? 0 : gcnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gen_en = 1'b0;
        pwm_in = 1'b0;
        reset  = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic start_gen(input int per, input int hi);
        gen_per = per;
        gen_hi  = hi;
        gcnt    = 0;
        gen_en  = 1'b1;
    endtask

    task automatic wait_valid(input int max_steps, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < max_steps) begin
            step();
            n++;
            if (duty_valid) ok = 1'b1;
        end
    endtask

    int  d_list[5] = '{1, 64, 128, 200, 255};
    int  n;
    bit  ok;
    int  nv, nbad, nstuck, ov_at, v1, v2, d1, p1, h1;

    initial begin
        // Reset state
        do_reset();
        check("rst_duty", duty_cycle, 0);
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        check("rst_valid", duty_valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_overrun", overrun_err, 0);

        // Loopback, period 256; second rising edge at step 257 -> valid at 268
        foreach (d_list[i]) begin
            do_reset();
            start_gen(256, d_list[i]);
            wait_valid(600, n, ok);
            check("lb_ok", ok, 1);
            check("lb_latency", n, 268);
            check("lb_duty", duty_cycle, d_list[i]);
            check("lb_period", period_out, 256);
            check("lb_high", high_out, d_list[i]);
            check("lb_stuck", stuck, 0);
            wait_valid(300, n, ok);
            check("lb_interval", n, 256);
            check("lb_duty2", duty_cycle, d_list[i]);
        end

        // Constant low: timeout report, repeating every 1024 cycles
        do_reset();
        wait_valid(1100, n, ok);
        check("tmo_first", n, 1024);
        check("tmo_duty", duty_cycle, 0);
        check("tmo_stuck", stuck, 1);
        check("tmo_period", period_out, 0);
        wait_valid(1100, n, ok);
        check("tmo_repeat", n, 1024);
        check("tmo_stuck2", stuck, 1);

        // Held high after edges, then recovery
        do_reset();
        start_gen(256, 128);
        wait_valid(600, n, ok);
        check("hi_pre_duty", duty_cycle, 128);
        gen_en = 1'b0;
        pwm_in = 1'b1;
        wait_valid(1200, n, ok);
        check("hi_tmo_ok", ok, 1);
        check("hi_tmo_duty", duty_cycle, 255);
        check("hi_tmo_stuck", stuck, 1);
        check("hi_tmo_period", period_out, 256);
        check("hi_tmo_high", high_out, 128);
        pwm_in = 1'b0;
        repeat (4) step();
        start_gen(256, 64);
        n = 0;
        while (stuck && n < 8) begin
            step();
            n++;
        end
        check("hi_stuck_clr", stuck, 0);
        wait_valid(600, n, ok);
        check("hi_rec_duty", duty_cycle, 64);
        check("hi_rec_high", high_out, 64);
        check("hi_rec_period", period_out, 256);

        // Period 6 / high 3: edges at sample 2,8,14,20; results at 18 and 30
        do_reset();
        start_gen(6, 3);
        ov_at = -1; v1 = -1; v2 = -1; d1 = -1; p1 = -1; h1 = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (overrun_err && ov_at < 0) ov_at = k;
            if (duty_valid) begin
                if (v1 < 0) begin
                    v1 = k; d1 = duty_cycle; p1 = period_out; h1 = high_out;
                end else if (v2 < 0) begin
                    v2 = k;
                end
            end
        end
        check("p6_overrun_at", ov_at, 14);
        check("p6_valid_at", v1, 18);
        check("p6_duty", d1, 128);
        check("p6_period", p1, 6);
        check("p6_high", h1, 3);
        check("p6_valid2_at", v2, 30);

        // Reset at E+5 of the first measured period aborts the division
        do_reset();
        start_gen(20, 10);
        repeat (26) step();
        gen_en = 1'b0;
        pwm_in = 1'b0;
        reset  = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("ab_valid", duty_valid, 0);
        check("ab_duty", duty_cycle, 0);
        check("ab_period", period_out, 0);
        check("ab_high", high_out, 0);
        nv = 0;
        repeat (15) begin
            step();
            if (duty_valid) nv++;
        end
        check("ab_no_valid", nv, 0);
        start_gen(20, 10);
        wait_valid(100, n, ok);
        check("ab_first_meas", n, 32);
        check("ab_duty2", duty_cycle, 128);
        check("ab_period2", period_out, 20);

        // Period 1024: each rising edge lands exactly on the timeout cycle
        do_reset();
        start_gen(1024, 512);
        nv = 0; nbad = 0; nstuck = 0;
        repeat (3100) begin
            step();
            if (stuck) nstuck++;
            if (duty_valid) begin
                nv++;
                if (duty_cycle != 8'd128 || period_out != 16'd1024 || high_out != 16'd512)
                    nbad++;
            end
        end
        check("et_valid_cnt", nv, 3);
        check("et_bad_meas", nbad, 0);
        check("et_stuck", nstuck, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
